// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns memory-stage load/store requests into a registered
// req/ack handshake, stalls the pipeline while the access is outstanding, and aborts on timeout.
module dmem_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic        ByteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        Enable,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        AlignErr,
  output logic        TimeoutErr
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  // Abort fires in the REQ cycle whose increment would make the counter reach TIMEOUT.
  localparam logic [4:0] TimeoutLast = 5'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        byte_q, byte_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] rdata_q, rdata_d;
  logic        align_err_q, align_err_d;
  logic        timeout_err_q, timeout_err_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        enable;
  logic [31:0] rdata_shifted;

  assign rdata_shifted = mem_rdata >> {lane_q, 3'b000};

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_be_d      = mem_be_q;
    mem_wdata_d   = mem_wdata_q;
    byte_d        = byte_q;
    lane_d        = lane_q;
    rdata_d       = rdata_q;
    align_err_d   = align_err_q;
    timeout_err_d = timeout_err_q;
    cnt_d         = cnt_q;
    enable        = 1'b0;

    case (state_q)
      StIdle: begin
        enable = ~(MemReadM | MemWriteM);
        if (MemReadM | MemWriteM) begin
          state_d     = StReq;
          mem_req_d   = 1'b1;
          mem_we_d    = MemWriteM;
          mem_addr_d  = {ALUOutM[31:2], 2'b00};
          mem_be_d    = ByteM ? (4'b0001 << ALUOutM[1:0]) : 4'b1111;
          mem_wdata_d = ByteM ? {4{WriteDataM[7:0]}} : WriteDataM;
          byte_d      = ByteM;
          lane_d      = ALUOutM[1:0];
          cnt_d       = 5'd0;
          if (!ByteM && (ALUOutM[1:0] != 2'b00)) begin
            align_err_d = 1'b1;
          end
        end
      end
      StReq: begin
        // Ack wins over a timeout reached in the same cycle.
        if (mem_ack) begin
          state_d   = StDone;
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            rdata_d = byte_q ? {24'd0, rdata_shifted[7:0]} : mem_rdata;
          end
        end else if (cnt_q == TimeoutLast) begin
          state_d       = StDone;
          mem_req_d     = 1'b0;
          timeout_err_d = 1'b1;
          if (!mem_we_q) begin
            rdata_d = 32'hDEADBEEF;
          end
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      StDone: begin
        enable  = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 32'd0;
      mem_be_q      <= 4'd0;
      mem_wdata_q   <= 32'd0;
      byte_q        <= 1'b0;
      lane_q        <= 2'd0;
      rdata_q       <= 32'd0;
      align_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= 5'd0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_be_q      <= mem_be_d;
      mem_wdata_q   <= mem_wdata_d;
      byte_q        <= byte_d;
      lane_q        <= lane_d;
      rdata_q       <= rdata_d;
      align_err_q   <= align_err_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign Enable     = enable;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
  assign ReadDataM  = rdata_q;
  assign AlignErr   = align_err_q;
  assign TimeoutErr = timeout_err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: inputs change and outputs are sampled around the falling edge.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM, ByteM;
  logic [31:0] ALUOutM, WriteDataM, ReadDataM;
  logic        Enable, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_ack, AlignErr, TimeoutErr;

  int checks = 0;
  int failures = 0;
  int nreq;

  always #5 clk = ~clk;

  dmem_ctrl #(.TIMEOUT(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .ByteM      (ByteM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .Enable     (Enable),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .AlignErr   (AlignErr),
    .TimeoutErr (TimeoutErr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; MemReadM = 0; MemWriteM = 0; ByteM = 0;
    ALUOutM = 0; WriteDataM = 0; mem_ack = 0; mem_rdata = 0;
    cyc(); #1;
    chk("rst_enable", 32'(Enable), 32'd1);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_rdata", ReadDataM, 32'd0);
    chk("rst_errs", {30'd0, AlignErr, TimeoutErr}, 32'd0);
    MemReadM = 1; #1;
    chk("rst_enable_req", 32'(Enable), 32'd0);

    // Word load 0x100
    cyc(); reset = 0; MemReadM = 1; ALUOutM = 32'h100; #1;
    chk("wl_stall_n", 32'(Enable), 32'd0);
    cyc(); #1;
    chk("wl_req", 32'(mem_req), 32'd1);
    chk("wl_we", 32'(mem_we), 32'd0);
    chk("wl_addr", mem_addr, 32'h100);
    chk("wl_be", 32'(mem_be), 32'hF);
    chk("wl_stall_n1", 32'(Enable), 32'd0);
    mem_ack = 1; mem_rdata = 32'h12345678;
    cyc(); mem_ack = 0; #1;
    chk("wl_enable_n2", 32'(Enable), 32'd1);
    chk("wl_req_drop", 32'(mem_req), 32'd0);
    chk("wl_rdata", ReadDataM, 32'h12345678);
    MemReadM = 0;
    cyc(); #1;
    chk("wl_idle_enable", 32'(Enable), 32'd1);

    // Byte store 0x203
    MemWriteM = 1; ByteM = 1; ALUOutM = 32'h203; WriteDataM = 32'hAABBCCDD;
    cyc(); #1;
    chk("bs_addr", mem_addr, 32'h200);
    chk("bs_be", 32'(mem_be), 32'h8);
    chk("bs_wdata", mem_wdata, 32'hDDDDDDDD);
    chk("bs_we", 32'(mem_we), 32'd1);
    mem_ack = 1; mem_rdata = 32'h55555555;
    cyc(); mem_ack = 0; MemWriteM = 0; #1;
    chk("bs_enable", 32'(Enable), 32'd1);
    chk("bs_rdata_hold", ReadDataM, 32'h12345678);

    // Byte load 0x301
    cyc(); MemReadM = 1; ByteM = 1; ALUOutM = 32'h301;
    cyc(); #1;
    chk("bl_be", 32'(mem_be), 32'h2);
    chk("bl_addr", mem_addr, 32'h300);
    mem_ack = 1; mem_rdata = 32'h11223344;
    cyc(); mem_ack = 0; MemReadM = 0; ByteM = 0; #1;
    chk("bl_rdata", ReadDataM, 32'h00000033);

    // Read and write together behave as a store
    cyc(); MemReadM = 1; MemWriteM = 1; ALUOutM = 32'h400; WriteDataM = 32'h01020304;
    cyc(); #1;
    chk("rw_we", 32'(mem_we), 32'd1);
    chk("rw_wdata", mem_wdata, 32'h01020304);
    mem_ack = 1; mem_rdata = 32'h77777777;
    cyc(); mem_ack = 0; MemReadM = 0; MemWriteM = 0; #1;
    chk("rw_rdata_hold", ReadDataM, 32'h00000033);

    // Ack on the final allowed REQ cycle succeeds
    cyc(); MemReadM = 1; ALUOutM = 32'h600;
    nreq = 0;
    for (int i = 0; i < 14; i++) begin
      cyc(); #1;
      if (mem_req) nreq++;
    end
    chk("late_req_cycles", 32'(nreq), 32'd14);
    cyc(); #1;
    chk("late_req_still", 32'(mem_req), 32'd1);
    mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    cyc(); mem_ack = 0; MemReadM = 0; #1;
    chk("late_rdata", ReadDataM, 32'hCAFEF00D);
    chk("late_no_timeout", 32'(TimeoutErr), 32'd0);

    // Timeout without ack
    cyc(); MemReadM = 1; ALUOutM = 32'h500;
    nreq = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(); #1;
      if (!mem_req) break;
      nreq++;
    end
    chk("to_req_cycles", 32'(nreq), 32'd15);
    chk("to_enable", 32'(Enable), 32'd1);
    chk("to_err", 32'(TimeoutErr), 32'd1);
    chk("to_rdata", ReadDataM, 32'hDEADBEEF);
    MemReadM = 0;
    // Stray ack while idle
    cyc(); mem_ack = 1; mem_rdata = 32'h44444444;
    cyc(); mem_ack = 0; #1;
    chk("idle_ack_ignored", ReadDataM, 32'hDEADBEEF);

    // Misaligned word load 0x102
    chk("al_pre", 32'(AlignErr), 32'd0);
    MemReadM = 1; ALUOutM = 32'h102;
    cyc(); #1;
    chk("al_err", 32'(AlignErr), 32'd1);
    chk("al_addr", mem_addr, 32'h100);
    chk("al_be", 32'(mem_be), 32'hF);
    mem_ack = 1; mem_rdata = 32'h0000ABCD;
    cyc(); mem_ack = 0; MemReadM = 0; #1;
    chk("al_rdata", ReadDataM, 32'h0000ABCD);
    cyc(); cyc(); #1;
    chk("al_sticky", 32'(AlignErr), 32'd1);

    // Reset mid-REQ then a stray ack
    MemReadM = 1; ALUOutM = 32'h700;
    cyc(); #1;
    chk("mr_req", 32'(mem_req), 32'd1);
    reset = 1; MemReadM = 0; #1;
    chk("mr_req_cleared", 32'(mem_req), 32'd0);
    chk("mr_addr_cleared", mem_addr, 32'd0);
    chk("mr_rdata_cleared", ReadDataM, 32'd0);
    chk("mr_errs_cleared", {30'd0, AlignErr, TimeoutErr}, 32'd0);
    cyc(); reset = 0; mem_ack = 1; mem_rdata = 32'h99999999;
    cyc(); mem_ack = 0; #1;
    chk("mr_stray_rdata", ReadDataM, 32'd0);
    chk("mr_stray_req", 32'(mem_req), 32'd0);
    MemReadM = 1; ALUOutM = 32'h800;
    cyc(); #1;
    chk("mr_next_addr", mem_addr, 32'h800);
    mem_ack = 1; mem_rdata = 32'h0BADF00D;
    cyc(); mem_ack = 0; MemReadM = 0; #1;
    chk("mr_next_rdata", ReadDataM, 32'h0BADF00D);
    chk("mr_next_enable", 32'(Enable), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
